// File: rtl/game_pkg.sv
// Shared definitions for the game objects that feed the video controller:
// screen geometry, coordinate and colour types, the player bitmap and the
// object FSM encoding.
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;
    localparam int SPRITE_W = 256;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic signed [COORD_W:0] delta_t;
    typedef logic [7:0] rgb332_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_REQ  = 2'd2
    } state_t;

    localparam rgb332_t PLAYER_COLOR = 8'hFC;

    // 16x16 ship, row-major, bit 255 is pixel (0,0).
    localparam logic [SPRITE_W-1:0] PLAYER_SPRITE = {
        16'h0180, 16'h03C0, 16'h03C0, 16'h07E0,
        16'h07E0, 16'h0FF0, 16'h1FF8, 16'h3FFC,
        16'h7FFE, 16'hFFFF, 16'hFFFF, 16'hF99F,
        16'hE187, 16'hC183, 16'h8181, 16'h0000
    };

    // Apply a signed step to a coordinate and saturate it to 0..max_pos.
    function automatic coord_t clamp_step(input coord_t pos, input delta_t delta,
                                          input coord_t max_pos);
        delta_t sum;
        coord_t result;
        sum = $signed({1'b0, pos}) + delta;
        if (sum < 0)
            result = '0;
        else if (sum > $signed({1'b0, max_pos}))
            result = max_pos;
        else
            result = sum[COORD_W-1:0];
        return result;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus debounce counter for one raw active-low key.
// The accepted level only changes after the synchronised level has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic pressed
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Synchronise the key and accept a new level only once it has held long enough.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync   <= 2'b11;
            stable <= 1'b1;
            cnt    <= '0;
        end else begin
            sync <= {sync[0], key_raw};
            if (sync[1] != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync[1];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign pressed = ~stable;

endmodule

// File: rtl/player_controller.sv
// Player object: conditions the keys, moves the sprite once per frame tick
// with edge saturation, and hands each changed position to the video
// controller through a write_enable/ack handshake.
module player_controller
    import game_pkg::*;
#(
    parameter int PLAYER_SIZE     = 16,
    parameter int START_X         = 312,
    parameter int START_Y         = 400,
    parameter int STEP            = 2,
    parameter int TICK_DIV        = 833333,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                keyRestart,
    input  logic                keyUp,
    input  logic                keyDown,
    input  logic                keyLeft,
    input  logic                keyRight,
    input  logic                player_write_ack,
    output logic [COORD_W-1:0]  player_x,
    output logic [COORD_W-1:0]  player_y,
    output logic [COORD_W-1:0]  player_size,
    output logic [SPRITE_W-1:0] player_sprite,
    output logic [7:0]          player_color,
    output logic                player_write_enable,
    output logic                player_moving
);

    localparam int K_RIGHT   = 0;
    localparam int K_LEFT    = 1;
    localparam int K_DOWN    = 2;
    localparam int K_UP      = 3;
    localparam int K_RESTART = 4;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    localparam coord_t X_MAX   = COORD_W'(SCREEN_W - PLAYER_SIZE);
    localparam coord_t Y_MAX   = COORD_W'(SCREEN_H - PLAYER_SIZE);
    localparam coord_t X_START = COORD_W'(START_X);
    localparam coord_t Y_START = COORD_W'(START_Y);
    localparam delta_t D_POS   = (COORD_W+1)'(STEP);
    localparam delta_t D_NEG   = (COORD_W+1)'(-STEP);

    logic [4:0] key_raw;
    logic [4:0] key_pressed;
    logic [TICK_W-1:0] tick_cnt;
    logic tick;
    logic restart_prev;
    logic restart_edge;
    delta_t dx, dy;
    coord_t cand_x, cand_y;
    state_t state, state_next;
    coord_t x_next, y_next;
    logic moving_next;

    assign key_raw = {keyRestart, keyUp, keyDown, keyLeft, keyRight};

    for (genvar i = 0; i < 5; i++) begin : g_keys
        key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk     (CLOCK_50),
            .reset   (reset),
            .key_raw (key_raw[i]),
            .pressed (key_pressed[i])
        );
    end

    // Free-running frame divider; tick marks the wrap cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Remember the debounced restart level to detect its press edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            restart_prev <= 1'b0;
        else
            restart_prev <= key_pressed[K_RESTART];
    end

    assign restart_edge = key_pressed[K_RESTART] & ~restart_prev;

    // Opposing keys on an axis cancel; diagonal movement combines both axes.
    assign dx = (key_pressed[K_RIGHT] && !key_pressed[K_LEFT]) ? D_POS :
                (key_pressed[K_LEFT] && !key_pressed[K_RIGHT]) ? D_NEG : '0;
    assign dy = (key_pressed[K_DOWN] && !key_pressed[K_UP]) ? D_POS :
                (key_pressed[K_UP] && !key_pressed[K_DOWN]) ? D_NEG : '0;

    assign cand_x = clamp_step(player_x, dx, X_MAX);
    assign cand_y = clamp_step(player_y, dy, Y_MAX);

    // State and published outputs; reset forces an initial draw request.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state         <= ST_REQ;
            player_x      <= X_START;
            player_y      <= Y_START;
            player_moving <= 1'b0;
        end else begin
            state         <= state_next;
            player_x      <= x_next;
            player_y      <= y_next;
            player_moving <= moving_next;
        end
    end

    // Next-state logic; restart overrides any tick or ack in the same cycle.
    // NOTE: every signal gets a hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        x_next      = player_x;
        y_next      = player_y;
        moving_next = player_moving;
        if (restart_edge) begin
            state_next  = ST_REQ;
            x_next      = X_START;
            y_next      = Y_START;
            moving_next = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick)
                        state_next = ST_CALC;
                end
                ST_CALC: begin
                    if (cand_x != player_x || cand_y != player_y) begin
                        x_next      = cand_x;
                        y_next      = cand_y;
                        moving_next = 1'b1;
                        state_next  = ST_REQ;
                    end else begin
                        moving_next = 1'b0;
                        state_next  = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (player_write_ack)
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign player_write_enable = (state == ST_REQ);
    assign player_size         = COORD_W'(PLAYER_SIZE);
    assign player_sprite       = PLAYER_SPRITE;
    assign player_color        = PLAYER_COLOR;

endmodule
